// File: rtl/ws2812_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_driver_if
// Purpose  : Pixel valid/ready handshake between a pixel producer and the
//            WS2812 serialiser. The brightness signal exists only when
//            WS2812_BRIGHTNESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ws2812_driver_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  modport master (
    output pix_data,
    output pix_valid,
`ifdef WS2812_BRIGHTNESS_EN
    output brightness,
`endif
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
`ifdef WS2812_BRIGHTNESS_EN
    input  brightness,
`endif
    output pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/ws2812_driver.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_driver
// Purpose  : Serialises 24-bit GRB pixels onto the WS2812 data pin, counts
//            pixels per frame and emits the latch low period at frame end.
//            Optional WS2812_BRIGHTNESS_EN adds a global brightness scaler.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_driver #(
  parameter int NUM_LEDS = 1,
  parameter int T0H      = 11,
  parameter int T1H      = 22,
  parameter int T_BIT    = 34,
  parameter int T_RST    = 2160
) (
  input  wire            CLK,
  input  wire            RESET,
  ws2812_driver_if.slave pix,
  output logic           dout,
  output logic           busy,
  output logic           frame_done
);

  localparam int c_cnt_w = $clog2(T_RST + 1);
  localparam int c_pix_w = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [c_cnt_w-1:0] c_t0h_ld   = c_cnt_w'(T0H - 1);
  localparam logic [c_cnt_w-1:0] c_t1h_ld   = c_cnt_w'(T1H - 1);
  localparam logic [c_cnt_w-1:0] c_t0l_ld   = c_cnt_w'(T_BIT - T0H - 1);
  localparam logic [c_cnt_w-1:0] c_t1l_ld   = c_cnt_w'(T_BIT - T1H - 1);
  localparam logic [c_cnt_w-1:0] c_rst_ld   = c_cnt_w'(T_RST - 1);
  localparam logic [c_pix_w-1:0] c_last_pix = c_pix_w'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    S_LATCH = 2'd0,
    S_IDLE  = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t             r_state,   w_state;
  logic [c_cnt_w-1:0] r_cnt,     w_cnt;
  logic [23:0]        r_shift,   w_shift;
  logic [4:0]         r_bit_idx, w_bit_idx;
  logic [c_pix_w-1:0] r_pix_cnt, w_pix_cnt;
  logic               r_boot,    w_boot;
  logic [23:0]        w_load;

`ifdef WS2812_BRIGHTNESS_EN
  // (c * (b + 1)) >> 8 : b = 255 is an exact pass-through, b = 0 blanks.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] w_prod;
    w_prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return w_prod[15:8];
  endfunction

  assign w_load = {scale_chan(pix.pix_data[23:16], pix.brightness),
                   scale_chan(pix.pix_data[15:8],  pix.brightness),
                   scale_chan(pix.pix_data[7:0],   pix.brightness)};
`else
  assign w_load = pix.pix_data;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_LATCH;
      r_cnt     <= c_rst_ld;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_pix_cnt <= '0;
      r_boot    <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_shift   <= w_shift;
      r_bit_idx <= w_bit_idx;
      r_pix_cnt <= w_pix_cnt;
      r_boot    <= w_boot;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_cnt         = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_shift       = r_shift;
    w_bit_idx     = r_bit_idx;
    w_pix_cnt     = r_pix_cnt;
    w_boot        = r_boot;
    dout          = 1'b0;
    busy          = 1'b1;
    frame_done    = 1'b0;
    pix.pix_ready = 1'b0;

    case (r_state)
      S_LATCH: begin
        if (r_cnt == '0) begin
          w_state    = S_IDLE;
          w_cnt      = c_rst_ld;
          // The latch that follows reset completes no frame.
          frame_done = ~r_boot;
          w_boot     = 1'b0;
        end
      end

      S_IDLE: begin
        busy          = 1'b0;
        pix.pix_ready = 1'b1;
        if (pix.pix_valid) begin
          w_state   = S_HIGH;
          w_shift   = w_load;
          w_bit_idx = 5'd23;
          w_cnt     = w_load[23] ? c_t1h_ld : c_t0h_ld;
        end else if (r_cnt == '0 && r_pix_cnt != '0) begin
          // Producer stalled long enough for the LEDs to latch on their own.
          w_pix_cnt  = '0;
          frame_done = 1'b1;
        end
      end

      S_HIGH: begin
        dout = 1'b1;
        if (r_cnt == '0) begin
          w_state = S_LOW;
          w_cnt   = r_shift[23] ? c_t1l_ld : c_t0l_ld;
        end
      end

      S_LOW: begin
        if (r_cnt == '0) begin
          if (r_bit_idx != 5'd0) begin
            w_state   = S_HIGH;
            w_shift   = {r_shift[22:0], 1'b0};
            w_bit_idx = r_bit_idx - 5'd1;
            w_cnt     = r_shift[22] ? c_t1h_ld : c_t0h_ld;
          end else if (r_pix_cnt == c_last_pix) begin
            w_state   = S_LATCH;
            w_pix_cnt = '0;
            w_cnt     = c_rst_ld;
          end else begin
            w_state   = S_IDLE;
            w_pix_cnt = r_pix_cnt + 1'b1;
            w_cnt     = c_rst_ld;
          end
        end
      end

      default: begin
        w_state = S_LATCH;
        w_cnt   = c_rst_ld;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_driver
// Purpose  : Directed bench for ws2812_driver: one DUT with NUM_LEDS=1 and one
//            with NUM_LEDS=3; brightness cases run with WS2812_BRIGHTNESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_driver;

  localparam int c_t0h   = 11;
  localparam int c_t1h   = 22;
  localparam int c_t_bit = 34;
  localparam int c_t_rst = 2160;

  logic CLK = 1'b0;
  logic RESET;
  logic dout_a, busy_a, fd_sig_a;
  logic dout_b, busy_b, fd_sig_b;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_a    = 0;
  int fd_b    = 0;

  ws2812_driver_if if_a ();
  ws2812_driver_if if_b ();

  always #5 CLK = ~CLK;

  ws2812_driver #(.NUM_LEDS(1)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .pix(if_a),
    .dout(dout_a), .busy(busy_a), .frame_done(fd_sig_a)
  );

  ws2812_driver #(.NUM_LEDS(3)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .pix(if_b),
    .dout(dout_b), .busy(busy_b), .frame_done(fd_sig_b)
  );

  always @(negedge CLK) begin
    if (fd_sig_a === 1'b1) fd_a++;
    if (fd_sig_b === 1'b1) fd_b++;
  end

  function automatic logic dout_of(input bit sel);
    return sel ? dout_b : dout_a;
  endfunction

  function automatic logic ready_of(input bit sel);
    return sel ? if_b.pix_ready : if_a.pix_ready;
  endfunction

  // Decodes one pixel from the pin; bad counts malformed highs/periods.
  task automatic recv_pixel(input bit sel, output logic [23:0] data,
                            output int bad, output bit rdy_seen);
    int h, l, w;
    bad = 0; rdy_seen = 0; data = '0; w = 0;
    while (dout_of(sel) !== 1'b1 && w < 10000) begin @(negedge CLK); w++; end
    if (w >= 10000) begin bad = 99; return; end
    for (int b = 23; b >= 0; b--) begin
      h = 0;
      while (dout_of(sel) === 1'b1 && h < 100) begin
        if (ready_of(sel) === 1'b1) rdy_seen = 1;
        h++; @(negedge CLK);
      end
      data[b] = (h == c_t1h);
      if (h != c_t0h && h != c_t1h) bad++;
      if (b != 0) begin
        l = 0;
        while (dout_of(sel) !== 1'b1 && l < 100) begin
          if (ready_of(sel) === 1'b1) rdy_seen = 1;
          l++; @(negedge CLK);
        end
        if (h + l != c_t_bit) bad++;
      end
    end
  endtask

  // Streams three pixels into DUT B with valid held high; tail = samples
  // from the first low cycle of the final bit up to the frame_done cycle.
  task automatic run_frame3(input logic [23:0] p0, p1, p2,
                            output logic [23:0] g0, g1, g2,
                            output int bad, output int gap_err, output int tail);
    int b0, b1, b2;
    bit r;
    gap_err = 0;
    fork
      begin
        int w;
        for (int i = 0; i < 3; i++) begin
          if_b.pix_data  = (i == 0) ? p0 : (i == 1) ? p1 : p2;
          if_b.pix_valid = 1'b1;
          w = 0;
          while (if_b.pix_ready !== 1'b1 && w < 5000) begin @(negedge CLK); w++; end
          @(negedge CLK);
          if (if_b.pix_ready !== 1'b0 || w >= 5000) gap_err++;
        end
        if_b.pix_valid = 1'b0;
      end
      begin
        recv_pixel(1'b1, g0, b0, r);
        recv_pixel(1'b1, g1, b1, r);
        recv_pixel(1'b1, g2, b2, r);
        tail = 1;
        while (fd_sig_b !== 1'b1 && tail < 5000) begin @(negedge CLK); tail++; end
      end
    join
    bad = b0 + b1 + b2;
  endtask

  task automatic test_reset();
    int n, snap_a, snap_b;
    bit dout_hi, fd_hi;
    RESET = 1'b1;
    if_a.pix_valid = 1'b0; if_a.pix_data = '0;
    if_b.pix_valid = 1'b0; if_b.pix_data = '0;
`ifdef WS2812_BRIGHTNESS_EN
    if_a.brightness = 8'd255; if_b.brightness = 8'd255;
`endif
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({dout_a, if_a.pix_ready, busy_a, fd_sig_a} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_state_a: got %b expected 0010", {dout_a, if_a.pix_ready, busy_a, fd_sig_a});
    end
    n_tests++;
    if ({dout_b, if_b.pix_ready, busy_b, fd_sig_b} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_state_b: got %b expected 0010", {dout_b, if_b.pix_ready, busy_b, fd_sig_b});
    end
    snap_a = fd_a; snap_b = fd_b;
    RESET = 1'b0;
    n = 0; dout_hi = 0; fd_hi = 0;
    while (if_a.pix_ready !== 1'b1 && n < 5000) begin
      n++;
      if (dout_a !== 1'b0 || dout_b !== 1'b0) dout_hi = 1;
      if (fd_sig_a !== 1'b0 || fd_sig_b !== 1'b0) fd_hi = 1;
      @(negedge CLK);
    end
    n_tests++;
    if (n != c_t_rst) begin n_fail++; $display("FAIL reset_latch_len: got %0d expected %0d", n, c_t_rst); end
    n_tests++;
    if (dout_hi || fd_hi) begin n_fail++; $display("FAIL reset_latch_quiet: dout_hi=%0b fd_hi=%0b expected 0 0", dout_hi, fd_hi); end
    n_tests++;
    if ({busy_a, if_b.pix_ready, busy_b} !== 3'b010) begin
      n_fail++; $display("FAIL reset_to_idle: got %b expected 010", {busy_a, if_b.pix_ready, busy_b});
    end
    n_tests++;
    if (fd_a != snap_a || fd_b != snap_b) begin
      n_fail++; $display("FAIL reset_no_frame_done: got %0d/%0d pulses expected 0/0", fd_a - snap_a, fd_b - snap_b);
    end
  endtask

  task automatic test_single_pixel();
    logic [23:0] got;
    int bad, n, snap;
    bit rdy;
    snap = fd_a;
    if_a.pix_data = 24'hA50FF0; if_a.pix_valid = 1'b1;
    @(negedge CLK);
    if_a.pix_valid = 1'b0; if_a.pix_data = 24'h5A5A5A;
    recv_pixel(1'b0, got, bad, rdy);
    n_tests++;
    if (got !== 24'hA50FF0) begin n_fail++; $display("FAIL single_data: got %h expected a50ff0", got); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL single_timing: got %0d bad bits expected 0", bad); end
    n_tests++;
    if (rdy) begin n_fail++; $display("FAIL single_ready_low: pix_ready seen 1 expected 0"); end
    n = 1;
    while (fd_sig_a !== 1'b1 && n < 5000) begin @(negedge CLK); n++; end
    n_tests++;
    if (n != (c_t_bit - c_t0h) + c_t_rst) begin
      n_fail++; $display("FAIL single_latch_len: got %0d expected %0d", n, (c_t_bit - c_t0h) + c_t_rst);
    end
    @(negedge CLK);
    n_tests++;
    if (fd_a != snap + 1 || if_a.pix_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_frame_done: got %0d pulses ready=%b expected 1 1", fd_a - snap, if_a.pix_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] g0, g1, g2;
    int bad, gap, tail, snap;
    snap = fd_b;
    run_frame3(24'h00FF00, 24'h8001AA, 24'h123456, g0, g1, g2, bad, gap, tail);
    n_tests++;
    if ({g0, g1, g2} !== {24'h00FF00, 24'h8001AA, 24'h123456}) begin
      n_fail++; $display("FAIL b2b_data: got %h %h %h expected 00ff00 8001aa 123456", g0, g1, g2);
    end
    n_tests++;
    if (bad != 0 || gap != 0) begin n_fail++; $display("FAIL b2b_timing: got bad=%0d gap=%0d expected 0 0", bad, gap); end
    n_tests++;
    if (tail != (c_t_bit - c_t0h) + c_t_rst) begin
      n_fail++; $display("FAIL b2b_latch_len: got %0d expected %0d", tail, (c_t_bit - c_t0h) + c_t_rst);
    end
    @(negedge CLK);
    n_tests++;
    if (fd_b != snap + 1) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses expected 1", fd_b - snap); end
  endtask

  task automatic test_timeout();
    logic [23:0] got, g0, g1, g2;
    int bad, gap, tail, n, snap;
    bit rdy;
    snap = fd_b;
    if_b.pix_data = 24'hC3C3C3; if_b.pix_valid = 1'b1;
    @(negedge CLK);
    if_b.pix_valid = 1'b0;
    recv_pixel(1'b1, got, bad, rdy);
    n_tests++;
    if (got !== 24'hC3C3C3 || bad != 0) begin
      n_fail++; $display("FAIL timeout_pixel: got %h bad=%0d expected c3c3c3 0", got, bad);
    end
    n = 1;
    while (fd_sig_b !== 1'b1 && n < 5000) begin @(negedge CLK); n++; end
    n_tests++;
    if (n != (c_t_bit - c_t1h) + c_t_rst || if_b.pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d ready=%b expected %0d 1", n, if_b.pix_ready, (c_t_bit - c_t1h) + c_t_rst);
    end
    @(negedge CLK);
    n_tests++;
    if (fd_b != snap + 1) begin n_fail++; $display("FAIL timeout_frame_done: got %0d pulses expected 1", fd_b - snap); end
    run_frame3(24'h111111, 24'h0F0F0F, 24'hFEDCBA, g0, g1, g2, bad, gap, tail);
    n_tests++;
    if ({g0, g1, g2} !== {24'h111111, 24'h0F0F0F, 24'hFEDCBA} || bad != 0 || gap != 0) begin
      n_fail++; $display("FAIL timeout_refill: got %h %h %h bad=%0d gap=%0d", g0, g1, g2, bad, gap);
    end
    n_tests++;
    if (tail != (c_t_bit - c_t0h) + c_t_rst) begin
      n_fail++; $display("FAIL timeout_refill_latch: got %0d expected %0d", tail, (c_t_bit - c_t0h) + c_t_rst);
    end
    @(negedge CLK);
    n_tests++;
    if (fd_b != snap + 2) begin n_fail++; $display("FAIL timeout_refill_fd: got %0d pulses expected 2", fd_b - snap); end
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  task automatic test_brightness();
    logic [23:0] got;
    logic [23:0] exp_px [2];
    logic [7:0]  lvl [2];
    int bad, n;
    bit rdy;
    lvl[0] = 8'd127; exp_px[0] = 24'h7F4001;
    lvl[1] = 8'd255; exp_px[1] = 24'hFF8002;
    for (int i = 0; i < 2; i++) begin
      if_a.brightness = lvl[i];
      if_a.pix_data = 24'hFF8002; if_a.pix_valid = 1'b1;
      @(negedge CLK);
      if_a.pix_valid = 1'b0;
      recv_pixel(1'b0, got, bad, rdy);
      n_tests++;
      if (got !== exp_px[i] || bad != 0) begin
        n_fail++; $display("FAIL brightness_%0d: got %h bad=%0d expected %h 0", lvl[i], got, bad, exp_px[i]);
      end
      n = 1;
      while (fd_sig_a !== 1'b1 && n < 5000) begin @(negedge CLK); n++; end
      @(negedge CLK);
      n_tests++;
      if (n >= 5000) begin n_fail++; $display("FAIL brightness_latch_%0d: no frame_done within %0d cycles", lvl[i], n); end
    end
    if_a.brightness = 8'd255;
  endtask
`endif

  task automatic test_reset_mid_pixel();
    int w, n, snap;
    bit dout_hi, rdy_hi;
    if_a.pix_data = 24'hFFFFFF; if_a.pix_valid = 1'b1;
    @(negedge CLK);
    if_a.pix_valid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      w = 0;
      while (dout_a === 1'b1 && w < 100) begin @(negedge CLK); w++; end
      w = 0;
      while (dout_a !== 1'b1 && w < 100) begin @(negedge CLK); w++; end
    end
    @(negedge CLK);
    n_tests++;
    if (dout_a !== 1'b1) begin n_fail++; $display("FAIL mid_bit10_high: got %b expected 1", dout_a); end
    snap = fd_a;
    #2 RESET = 1'b1;
    #1;
    n_tests++;
    if ({dout_a, if_a.pix_ready, busy_a} !== 3'b001) begin
      n_fail++; $display("FAIL mid_reset_async: got %b expected 001", {dout_a, if_a.pix_ready, busy_a});
    end
    @(negedge CLK);
    RESET = 1'b0;
    n = 0; dout_hi = 0;
    while (if_a.pix_ready !== 1'b1 && n < 5000) begin
      n++;
      if (dout_a !== 1'b0) dout_hi = 1;
      @(negedge CLK);
    end
    n_tests++;
    if (n != c_t_rst || dout_hi) begin
      n_fail++; $display("FAIL mid_relatch: got %0d cycles dout_hi=%0b expected %0d 0", n, dout_hi, c_t_rst);
    end
    rdy_hi = 1;
    repeat (100) begin
      if (dout_a !== 1'b0) dout_hi = 1;
      if (if_a.pix_ready !== 1'b1) rdy_hi = 0;
      @(negedge CLK);
    end
    n_tests++;
    if (dout_hi || !rdy_hi || fd_a != snap) begin
      n_fail++; $display("FAIL mid_no_resume: dout_hi=%0b ready=%0b fd=%0d expected 0 1 0", dout_hi, rdy_hi, fd_a - snap);
    end
  endtask

  initial begin
    RESET = 1'b1;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_timeout();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    test_reset_mid_pixel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached with %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
